// File: rtl/mips_register_file.sv
// MIPS general-purpose register file: 2**ADDR_W entries of DATA_W bits.
// Entry 0 is hard-wired to zero and has no storage. $gp and $sp come out of
// reset with their own preset values; every other entry clears to zero.
// Two combinational read ports (rs, rt), one clocked write port. With BYPASS=1
// a write in flight is forwarded to a read of the same index in that cycle.
// There is no handshake: a write is requested by reg_write=1 and is committed
// unconditionally on the next rising clk edge while rst_n is high.
module mips_register_file #(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 5,
    parameter logic [DATA_W-1:0]  SP_RESET = DATA_W'(32'h0000_3FFC),
    parameter logic [DATA_W-1:0]  GP_RESET = DATA_W'(32'h0000_1800),
    parameter bit                 BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int GP_IDX = 28;
    localparam int SP_IDX = 29;

    // Storage for entries 1..DEPTH-1 only; entry 0 is synthesised as a constant.
    logic [DATA_W-1:0] regs_q  [1:DEPTH-1];
    // One-hot write select, bit i set when entry i is written this edge.
    logic [DEPTH-1:1]  wr_sel_d;
    // Read view of the whole file including the constant-zero entry 0.
    logic [DATA_W-1:0] rd_view [0:DEPTH-1];
    logic              byp1;
    logic              byp2;

    // One-hot decode of the destination index, gated by the write enable.
    // Index 0 has no select bit, so writes to $zero fall on the floor.
    always_comb begin
        wr_sel_d = '0;
        for (int i = 1; i < DEPTH; i++) begin
            wr_sel_d[i] = reg_write && (write_reg == ADDR_W'(i));
        end
    end

    // Register storage: async reset to the preset image, else commit the selected entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (i == GP_IDX) begin
                    regs_q[i] <= GP_RESET;
                end else if (i == SP_IDX) begin
                    regs_q[i] <= SP_RESET;
                end else begin
                    regs_q[i] <= '0;
                end
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_sel_d[i]) begin
                    regs_q[i] <= write_data;
                end
            end
        end
    end

    // Present the stored entries with entry 0 forced to zero.
    always_comb begin
        rd_view[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            rd_view[i] = regs_q[i];
        end
    end

    // Forwarding conditions: a live, non-zero write to the index being read.
    // rst_n is included so nothing leaks through while the file is held in reset.
    assign byp1 = BYPASS && rst_n && reg_write && (write_reg != '0) && (write_reg == read_reg1);
    assign byp2 = BYPASS && rst_n && reg_write && (write_reg != '0) && (write_reg == read_reg2);

    assign read_data1 = byp1 ? write_data : rd_view[read_reg1];
    assign read_data2 = byp2 ? write_data : rd_view[read_reg2];

endmodule

// File: tb/tb_mips_register_file.sv
// Bench for mips_register_file: one instance with forwarding, one without,
// both driven by the same stimulus and compared against an array model.
module tb_mips_register_file;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    logic [31:0] model [0:31];

    mips_register_file #(.BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_b), .read_data2(rd2_b)
    );

    mips_register_file #(.BYPASS(1'b0)) dut_nob (
        .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_n), .read_data2(rd2_n)
    );

    // Clock: 10 time units, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] reset_value(input int idx);
        if (idx == 28) return 32'h0000_1800;
        if (idx == 29) return 32'h0000_3FFC;
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = reset_value(i);
    endtask

    // What a read port must show right now according to the register-file rules.
    function automatic logic [31:0] exp_read(input bit byp, input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (byp && rst_n && reg_write && write_reg == idx) return write_data;
        return model[idx];
    endfunction

    // Driver: apply a set of inputs just after a falling edge.
    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        reg_write  = we;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        #1;
    endtask

    // Let the rising edge happen and fold the committed write into the model.
    task automatic tick();
        @(posedge clk);
        if (rst_n && reg_write && write_reg != 5'd0) model[write_reg] = write_data;
    endtask

    task automatic step(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
        drive(we, wr, wd, r1, r2);
        tick();
    endtask

    // Asynchronous reset pulse in the middle of the low phase, spanning one rising edge.
    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #6;
        rst_n = 1'b1;
    endtask

    // Compare process: one time unit before each rising edge, all ports of both instances.
    always @(negedge clk) begin
        #4;
        if (check_en) begin
            check("rd1_byp", rd1_b, exp_read(1'b1, read_reg1));
            check("rd2_byp", rd2_b, exp_read(1'b1, read_reg2));
            check("rd1_nob", rd1_n, exp_read(1'b0, read_reg1));
            check("rd2_nob", rd2_n, exp_read(1'b0, read_reg2));
        end
    end

    initial begin
        rst_n = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0;
        #1;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;

        // Put some data in, then pulse reset mid-cycle and scan every index.
        step(1'b1, 5'd3, 32'h1234_5678, 5'd0, 5'd0);
        step(1'b1, 5'd31, 32'h0BAD_F00D, 5'd0, 5'd0);
        check_en = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 32; i++) begin
            reg_write  = 1'b1;
            write_reg  = 5'(i);
            write_data = $urandom;
            read_reg1  = 5'(i);
            read_reg2  = 5'(31 - i);
            #2;
            check($sformatf("reset_scan_rd1[%0d]", i), rd1_b, reset_value(i));
            check($sformatf("reset_scan_rd2[%0d]", 31 - i), rd2_n, reset_value(31 - i));
        end
        reg_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_en = 1'b1;

        // Basic write then read on both ports; neighbour write leaves it alone.
        step(1'b1, 5'd5, 32'h2020_203F, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        check("basic_rd1", rd1_n, 32'h2020_203F);
        check("basic_rd2", rd2_n, 32'h2020_203F);
        tick();
        step(1'b1, 5'd6, 32'h2020_2021, 5'd5, 5'd6);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        check("neighbour_5", rd1_n, 32'h2020_203F);
        check("neighbour_6", rd2_n, 32'h2020_2021);
        tick();

        // $zero stays zero, including during the write cycle.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        check("zero_during_byp", rd1_b, 32'h0);
        check("zero_during_nob", rd1_n, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        check("zero_after", rd1_b, 32'h0);
        tick();

        // Write disable for three edges.
        repeat (3) step(1'b0, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7);
        drive(1'b0, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7);
        check("wr_disable_byp", rd1_b, 32'h0);
        check("wr_disable_nob", rd1_n, 32'h0);
        tick();

        // Forwarding versus one-cycle latency.
        step(1'b1, 5'd9, 32'h1111_1111, 5'd0, 5'd0);
        drive(1'b1, 5'd9, 32'h2222_2222, 5'd9, 5'd9);
        check("bypass_on", rd1_b, 32'h2222_2222);
        check("bypass_off_before", rd1_n, 32'h1111_1111);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        check("bypass_off_after", rd1_n, 32'h2222_2222);
        check("bypass_on_after", rd2_b, 32'h2222_2222);
        tick();

        // Write-after-write on consecutive edges.
        step(1'b1, 5'd12, 32'hAAAA_0001, 5'd0, 5'd0);
        step(1'b1, 5'd12, 32'hAAAA_0002, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd0);
        check("waw_last_wins", rd1_n, 32'hAAAA_0002);
        tick();

        // Reset falling on the same edge as a write to 31.
        drive(1'b1, 5'd31, 32'hA5A5_A5A5, 5'd31, 5'd31);
        check("race_pre_bypass", rd1_b, 32'hA5A5_A5A5);
        @(posedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("race_byp", rd1_b, 32'h0);
        check("race_nob", rd1_n, 32'h0);
        drive(1'b0, 5'd31, 32'h0, 5'd31, 5'd29);
        rst_n = 1'b1;
        #1;
        check("race_release_31", rd1_n, 32'h0);
        check("race_release_sp", rd2_n, 32'h0000_3FFC);
        tick();
        // First edge after release takes a write.
        step(1'b1, 5'd31, 32'h5A5A_5A5A, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd28);
        check("first_write_after_release", rd1_n, 32'h5A5A_5A5A);
        check("gp_preset", rd2_n, 32'h0000_1800);
        tick();

        // Randomized traffic with read indices biased toward the write index.
        for (int n = 0; n < 600; n++) begin
            logic        we;
            logic [4:0]  wr, r1, r2;
            logic [31:0] wd;
            we = ($urandom_range(0, 3) != 0);
            wr = 5'($urandom_range(0, 31));
            wd = $urandom;
            r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 59) == 0) begin
                reg_write = we; write_reg = wr; write_data = wd;
                read_reg1 = r1; read_reg2 = r2;
                reset_pulse();
            end else begin
                step(we, wr, wd, r1, r2);
            end
        end

        @(negedge clk);
        #5;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the MIPS single-cycle datapath.
- It is the write/decode end of the write-back path. The 32-bit 2-to-1 write-back mux (MemtoReg) selects the data. This block decodes the 5-bit destination and stores the word on the clock edge.
- It provides two combinational read ports (rs, rt) that feed the ALU operand muxes.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- SP_RESET, 32'h0000_3FFC, reset value of register 29 ($sp).
- GP_RESET, 32'h0000_1800, reset value of register 28 ($gp).
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return stored value only.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous, active-low reset.
- reg_write  input  1  write enable (RegWrite control).
- write_reg  input  ADDR_W  destination register index (output of RegDst mux).
- write_data  input  DATA_W  write-back data (output of MemtoReg mux).
- read_reg1  input  ADDR_W  rs index.
- read_reg2  input  ADDR_W  rt index.
- read_data1  output  DATA_W  rs data, combinational.
- read_data2  output  DATA_W  rt data, combinational.

Behaviour:
- Storage: registers 1..31 are flops. Register 0 is not stored; it reads as 0 constantly.
- Reset:
  - rst_n low clears registers 1..27, 30 and 31 to 0 immediately, without waiting for clk.
  - Register 28 loads GP_RESET and register 29 loads SP_RESET.
  - While rst_n is low, every write is ignored, including one coincident with a clk edge.
  - Outputs follow the reset contents combinationally, so read_data1/2 = 0 for index 0 and for all cleared indices.
- Write:
  - On the rising clk edge with rst_n=1 and reg_write=1, write_data is stored into entry write_reg.
  - Writes to index 0 are discarded.
  - reg_write=0 leaves all entries unchanged, regardless of write_reg and write_data.
- Write decode: one-hot 5-to-32 decode of write_reg, gated by reg_write. Exactly one entry (or none) is updated per edge.
- Read: read_dataN = entry[read_regN], combinational, zero latency, with no clock involvement. Both ports are independent and may address the same entry.
- Bypass (BYPASS=1):
  - Condition: reg_write=1, write_reg==read_regN, write_reg!=0 and rst_n=1.
  - When the condition holds, read_dataN = write_data in the same cycle, before the edge.
  - When it does not hold, read_dataN returns the stored value.
  - Index 0 is never bypassed.
- BYPASS=0: the new value appears on read ports only after the writing edge (one-cycle latency).
- Reset release: the first write takes effect on the first rising edge after rst_n rises.
- Write-after-write: when consecutive edges write the same index, the last write wins.
- No X propagation requirement on unknown indices. The bench drives only known values.

Test Plan:
- Reset: pulse rst_n=0 asynchronously mid-cycle, then read all 32 indices -> 28 reads 32'h0000_1800, 29 reads 32'h0000_3FFC, every other index reads 0.
- Basic write/read: reg_write=1, write_reg=5, write_data=32'h2020_203F, one edge; then read_reg1=5, read_reg2=5 -> both ports 32'h2020_203F. Write index 6 with 32'h2020_2021 -> index 5 is unchanged.
- $zero: write_reg=0, write_data=32'hFFFF_FFFF, reg_write=1, one edge -> read_data1 (index 0) stays 0, including during the write cycle with BYPASS=1.
- Write disable: reg_write=0, write_reg=7, write_data=32'hDEAD_BEEF, three edges -> index 7 still reads its prior value 0.
- Bypass (BYPASS=1): index 9 holds 32'h1111_1111. Drive reg_write=1, write_reg=9, write_data=32'h2222_2222, read_reg1=9 -> read_data1=32'h2222_2222 before the edge. With BYPASS=0 -> 32'h1111_1111 before the edge and 32'h2222_2222 after it.
- Reset vs write race: reg_write=1, write_reg=31, write_data=32'hA5A5_A5A5, rst_n falls at the same clk edge -> index 31 reads 0. Index 31 also reads 0 after rst_n rises with reg_write=0.
